uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx_pkg.sv | 55 +++++
 rtl/uart_tx_if.sv | 11 +
 rtl/counter.sv | 25 ++
 rtl/uart_tx_datapath.sv | 78 +++++++
 rtl/uart_tx.sv | 122 ++++++++++++
 tb/tb_uart_tx.sv | 243 ++++++++++++++++++++++++
 6 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART types: transmit FSM states, transmit control points, receive types.
package uart_tx_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // Value loaded into the tx register at a bit boundary.
  typedef enum logic [2:0] {
    TXS_HOLD,
    TXS_ONE,
    TXS_ZERO,
    TXS_DATA,
    TXS_PARITY
  } tx_sel_t;

  typedef struct packed {
    logic    baud_load;
    logic    baud_en;
    logic    bit_clr;
    logic    bit_en;
    logic    stop_clr;
    logic    stop_en;
    logic    shift_load;
    logic    shift_en;
    tx_sel_t tx_sel;
  } tx_ctl_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef struct packed {
    logic frame_err;
    logic parity_err;
  } rx_status_t;

  // Even mode sends the XOR of the data bits, odd mode its inverse.
  function automatic logic parity_out(input int mode, input logic acc);
    return (mode == PAR_ODD) ? ~acc : acc;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/counter.sv
// Generic loadable up/down counter with synchronous clear.
module counter #(
  parameter int WIDTH = 4,
  parameter bit DOWN  = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);
  logic [WIDTH-1:0] r_count;

  // clear has priority over load, load over counting
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    r_count <= '0;
    else if (i_clr)  r_count <= '0;
    else if (i_load) r_count <= i_load_val;
    else if (i_en)   r_count <= DOWN ? (r_count - WIDTH'(1)) : (r_count + WIDTH'(1));
  end

  assign o_count = r_count;
endmodule

// File: rtl/uart_tx_datapath.sv
// Transmit datapath: baud/bit/stop counters, PISO shifter, parity and line register.
module tx_datapath
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_WIDTH   = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  tx_ctl_t               i_ctl,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_baud_tc,
  output logic                  o_bit_last,
  output logic                  o_stop_last,
  output logic                  o_tx
);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);

  logic [BAUD_W-1:0]     w_baud_cnt;
  logic [BIT_W-1:0]      w_bit_cnt;
  logic                  w_stop_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par;
  logic                  r_tx;

  counter #(.WIDTH(BAUD_W), .DOWN(1'b1)) u_baud_cnt (
    .clock(clock), .reset_n(reset_n), .i_clr(1'b0), .i_load(i_ctl.baud_load),
    .i_load_val(BAUD_RELOAD), .i_en(i_ctl.baud_en), .o_count(w_baud_cnt)
  );

  counter #(.WIDTH(BIT_W), .DOWN(1'b0)) u_bit_cnt (
    .clock(clock), .reset_n(reset_n), .i_clr(i_ctl.bit_clr), .i_load(1'b0),
    .i_load_val('0), .i_en(i_ctl.bit_en), .o_count(w_bit_cnt)
  );

  counter #(.WIDTH(1), .DOWN(1'b0)) u_stop_cnt (
    .clock(clock), .reset_n(reset_n), .i_clr(i_ctl.stop_clr), .i_load(1'b0),
    .i_load_val(1'b0), .i_en(i_ctl.stop_en), .o_count(w_stop_cnt)
  );

  assign o_baud_tc   = (w_baud_cnt == '0);
  assign o_bit_last  = (w_bit_cnt == BIT_W'(DATA_WIDTH - 1));
  assign o_stop_last = (w_stop_cnt == 1'(STOP_BITS - 1));

  // Shift register: bit 0 is always the next data bit to put on the line
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)              r_shift <= '0;
    else if (i_ctl.shift_load) r_shift <= i_data;
    else if (i_ctl.shift_en)   r_shift <= r_shift >> 1;
  end

  // Parity accumulates every data bit as it leaves the shifter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)              r_par <= 1'b0;
    else if (i_ctl.shift_load) r_par <= 1'b0;
    else if (i_ctl.shift_en)   r_par <= r_par ^ r_shift[0];
  end

  // Line register, idle high; updated only at bit boundaries
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_tx <= 1'b1;
    else begin
      case (i_ctl.tx_sel)
        TXS_ONE:    r_tx <= 1'b1;
        TXS_ZERO:   r_tx <= 1'b0;
        TXS_DATA:   r_tx <= r_shift[0];
        TXS_PARITY: r_tx <= parity_out(PARITY, r_par);
        default:    r_tx <= r_tx;
      endcase
    end
  end

  assign o_tx = r_tx;
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: frame sequencing FSM driving the tx_datapath control points.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic      clock,
  input  logic      reset_n,
  uart_tx_if.slave  s_if,
  output logic      tx,
  output logic      busy
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;

  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx: CLK_FREQ / BAUD_RATE must be at least 2");
  end

  tx_state_t r_state;
  logic      r_busy;
  tx_ctl_t   w_ctl;
  logic      w_baud_tc;
  logic      w_bit_last;
  logic      w_stop_last;

  assign s_if.tx_ready = (r_state == ST_IDLE);
  assign busy          = r_busy;

  // Control points for the datapath, decoded from state and counter status
  always_comb begin
    w_ctl = '0;
    w_ctl.tx_sel = TXS_HOLD;
    case (r_state)
      ST_IDLE: if (s_if.tx_valid) begin
        w_ctl.shift_load = 1'b1;
        w_ctl.baud_load  = 1'b1;
        w_ctl.bit_clr    = 1'b1;
        w_ctl.stop_clr   = 1'b1;
        w_ctl.tx_sel     = TXS_ZERO;
      end
      ST_START: if (w_baud_tc) begin
        w_ctl.baud_load = 1'b1;
        w_ctl.shift_en  = 1'b1;
        w_ctl.tx_sel    = TXS_DATA;
      end else w_ctl.baud_en = 1'b1;
      ST_DATA: if (w_baud_tc) begin
        w_ctl.baud_load = 1'b1;
        if (w_bit_last) begin
          w_ctl.bit_clr  = 1'b1;
          w_ctl.stop_clr = 1'b1;
          w_ctl.tx_sel   = (PARITY != PAR_NONE) ? TXS_PARITY : TXS_ONE;
        end else begin
          w_ctl.bit_en   = 1'b1;
          w_ctl.shift_en = 1'b1;
          w_ctl.tx_sel   = TXS_DATA;
        end
      end else w_ctl.baud_en = 1'b1;
      ST_PARITY: if (w_baud_tc) begin
        w_ctl.baud_load = 1'b1;
        w_ctl.stop_clr  = 1'b1;
        w_ctl.tx_sel    = TXS_ONE;
      end else w_ctl.baud_en = 1'b1;
      ST_STOP: if (w_baud_tc) begin
        if (!w_stop_last) begin
          w_ctl.baud_load = 1'b1;
          w_ctl.stop_en   = 1'b1;
        end
      end else w_ctl.baud_en = 1'b1;
      default: ;
    endcase
  end

  // State sequencing with registered busy
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (s_if.tx_valid) begin
          r_state <= ST_START;
          r_busy  <= 1'b1;
        end
        ST_START: if (w_baud_tc) r_state <= ST_DATA;
        ST_DATA: if (w_baud_tc && w_bit_last)
          r_state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
        ST_PARITY: if (w_baud_tc) r_state <= ST_STOP;
        ST_STOP: if (w_baud_tc && w_stop_last) begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  tx_datapath #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .DATA_WIDTH  (DATA_WIDTH),
    .PARITY      (PARITY),
    .STOP_BITS   (STOP_BITS)
  ) u_datapath (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_ctl      (w_ctl),
    .i_data     (s_if.tx_data),
    .o_baud_tc  (w_baud_tc),
    .o_bit_last (w_bit_last),
    .o_stop_last(w_stop_last),
    .o_tx       (tx)
  );
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances at 4 clocks/bit (none/even/odd parity, two stop bits).
module tb_uart_tx;
  localparam int CPB = 4;

  typedef struct {
    logic [15:0] bits;
    int          nbits;
  } frame_t;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] r_valid;
  logic [7:0] r_data [4];
  logic [3:0] w_tx, w_busy, w_ready;
  int         acc_cnt [4];
  int         cyc;
  int         n_checks;
  int         n_fail;
  frame_t     sb [$];

  always #5 clock = ~clock;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx_if #(.DATA_WIDTH(8)) u_if ();
    assign u_if.tx_valid = r_valid[g];
    assign u_if.tx_data  = r_data[g];
    assign w_ready[g]    = u_if.tx_ready;
    uart_tx #(
      .CLK_FREQ(400), .BAUD_RATE(100), .DATA_WIDTH(8),
      .PARITY(g == 1 ? 1 : (g == 2 ? 2 : 0)),
      .STOP_BITS(g == 3 ? 2 : 1)
    ) u_dut (
      .clock(clock), .reset_n(reset_n), .s_if(u_if), .tx(w_tx[g]), .busy(w_busy[g])
    );
  end

  // cycle count and accepted-byte count per instance
  always @(posedge clock) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 4; i++)
      if (reset_n && r_valid[i] && w_ready[i]) acc_cnt[i] <= acc_cnt[i] + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic frame_t build_frame(input int idx, input logic [7:0] d);
    frame_t f;
    int     par_mode;
    int     stops;
    logic   p;
    par_mode = (idx == 1) ? 1 : ((idx == 2) ? 2 : 0);
    stops    = (idx == 3) ? 2 : 1;
    f.bits   = '0;
    f.bits[0] = 1'b0;
    f.nbits  = 1;
    for (int i = 0; i < 8; i++) begin
      f.bits[f.nbits] = d[i];
      f.nbits++;
    end
    if (par_mode != 0) begin
      p = ^d;
      if (par_mode == 2) p = ~p;
      f.bits[f.nbits] = p;
      f.nbits++;
    end
    for (int i = 0; i < stops; i++) begin
      f.bits[f.nbits] = 1'b1;
      f.nbits++;
    end
    return f;
  endfunction

  task automatic send_byte(input int idx, input logic [7:0] d, input bit push);
    @(negedge clock);
    r_data[idx]  = d;
    r_valid[idx] = 1'b1;
    if (push) sb.push_back(build_frame(idx, d));
    @(posedge clock);
    #1;
    r_valid[idx] = 1'b0;
  endtask

  // Waits for the start bit, then checks every cycle of the frame against the scoreboard.
  task automatic check_frame(input int idx, output int fall_cyc);
    frame_t f;
    bit     found;
    found    = 1'b0;
    fall_cyc = -1;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clock);
      if (w_tx[idx] == 1'b0) found = 1'b1;
    end
    check_eq($sformatf("dut%0d_start_seen", idx), 32'(found), 1);
    if (sb.size() == 0) begin
      check_eq("scoreboard_nonempty", 0, 1);
      return;
    end
    f = sb.pop_front();
    if (!found) return;
    fall_cyc = cyc;
    for (int k = 0; k < f.nbits * CPB; k++) begin
      if (k > 0) @(negedge clock);
      check_eq($sformatf("dut%0d_line_bit%0d", idx, k / CPB), 32'(w_tx[idx]), 32'(f.bits[k / CPB]));
      check_eq($sformatf("dut%0d_ready_low", idx), 32'(w_ready[idx]), 0);
      if (k % CPB == 0) check_eq($sformatf("dut%0d_busy_high", idx), 32'(w_busy[idx]), 1);
    end
    @(negedge clock);
    check_eq($sformatf("dut%0d_ready_rise", idx), 32'(w_ready[idx]), 1);
    check_eq($sformatf("dut%0d_line_idle", idx), 32'(w_tx[idx]), 1);
    check_eq($sformatf("dut%0d_busy_drop", idx), 32'(w_busy[idx]), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         fa, fb, rel, base, got;
    logic [7:0] d;
    r_valid = '0;
    for (int i = 0; i < 4; i++) r_data[i] = 8'h00;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("rst_tx%0d", i), 32'(w_tx[i]), 1);
      check_eq($sformatf("rst_busy%0d", i), 32'(w_busy[i]), 0);
      check_eq($sformatf("rst_ready%0d", i), 32'(w_ready[i]), 1);
    end
    reset_n = 1'b1;

    // basic frame and a few random bytes, no parity
    send_byte(0, 8'hA5, 1); check_frame(0, fa);
    repeat (3) begin
      d = 8'($urandom_range(0, 255));
      send_byte(0, d, 1); check_frame(0, fa);
    end

    // even and odd parity
    send_byte(1, 8'h07, 1); check_frame(1, fa);
    send_byte(1, 8'hA5, 1); check_frame(1, fa);
    send_byte(2, 8'h07, 1); check_frame(2, fa);
    send_byte(2, 8'h35, 1); check_frame(2, fa);

    // two stop bits
    send_byte(3, 8'h7F, 1); check_frame(3, fa);
    send_byte(3, 8'hC2, 1); check_frame(3, fa);

    // back-to-back with tx_valid held
    base = acc_cnt[0];
    @(negedge clock);
    r_data[0]  = 8'h00;
    r_valid[0] = 1'b1;
    sb.push_back(build_frame(0, 8'h00));
    sb.push_back(build_frame(0, 8'hFF));
    fork
      begin
        check_frame(0, fa);
        check_frame(0, fb);
      end
      begin
        @(posedge clock);
        #1;
        r_data[0] = 8'hFF;
        got = 0;
        for (int t = 0; t < 100 && got == 0; t++) begin
          @(posedge clock);
          #1;
          if (acc_cnt[0] - base == 2) got = 1;
        end
        check_eq("b2b_second_accept", 32'(got), 1);
        r_valid[0] = 1'b0;
      end
    join
    check_eq("b2b_start_gap", 32'(fb - fa), 41);
    repeat (5) @(negedge clock);
    check_eq("b2b_accept_count", 32'(acc_cnt[0] - base), 2);

    // input isolation during DATA
    send_byte(0, 8'h5A, 1);
    fork
      check_frame(0, fa);
      begin
        repeat (10) @(negedge clock);
        for (int t = 0; t < 16; t++) begin
          r_valid[0] = ~r_valid[0];
          r_data[0]  = 8'($urandom);
          @(negedge clock);
        end
        r_valid[0] = 1'b0;
      end
    join

    // reset during data bit 3 aborts the frame immediately
    send_byte(0, 8'hC3, 0);
    @(negedge clock);
    repeat (17) @(negedge clock);
    check_eq("pre_reset_bit3", 32'(w_tx[0]), 0);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("reset_tx_high", 32'(w_tx[0]), 1);
    check_eq("reset_busy_low", 32'(w_busy[0]), 0);
    check_eq("reset_ready_high", 32'(w_ready[0]), 1);
    @(negedge clock);
    reset_n = 1'b1;
    for (int t = 0; t < 48; t++) begin
      @(negedge clock);
      check_eq("no_resume_tx", 32'(w_tx[0]), 1);
      check_eq("no_resume_busy", 32'(w_busy[0]), 0);
    end

    // handshake on the first edge after reset release, then a clean 8'h3C frame
    @(negedge clock);
    reset_n    = 1'b0;
    r_data[0]  = 8'h3C;
    r_valid[0] = 1'b1;
    sb.push_back(build_frame(0, 8'h3C));
    @(negedge clock);
    reset_n = 1'b1;
    rel = cyc;
    fork
      check_frame(0, fa);
      begin
        @(posedge clock);
        #1;
        r_valid[0] = 1'b0;
      end
    join
    check_eq("first_edge_accept", 32'(fa - rel), 1);
    check_eq("scoreboard_drained", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
